// File: rtl/victim_cache_control_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared types and constants for the victim cache controller.
//               victim_ctrl_state_t - controller FSM state encoding
//               VICTIM_CNT_W        - default performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  localparam int VICTIM_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIT    = 3'd1,
    FETCH  = 3'd2,
    WB     = 3'd3,
    VWRITE = 3'd4,
    DONE   = 3'd5
  } victim_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/victim_cache_control_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones. Synchronous clear wins
//               over increment in the same cycle.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset (count -> 0)
//               clr   - synchronous clear
//               inc   - increment enable
//               count - current count value [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/victim_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : victim_cache_control
// Description : Control FSM sequencing the victim cache datapath between the
//               L2 cache and physical memory. Serves L2 evictions (with a
//               writeback of any valid occupant first) and L2 read lookups
//               (hit from the buffer, miss forwarded to memory). Keeps
//               saturating hit / miss / writeback counters.
// Ports       : clk, rst_n            - clock, async active-low reset
//               v_read, v_write       - L2 requests (held until v_resp)
//               v_resp                - completion pulse to L2
//               read_hit, valid       - datapath status
//               victim_write, load_plru, load_plru_sel, address_sel
//                                     - datapath strobes
//               p_read, p_write, p_resp - physical memory handshake
//               clr_counts            - synchronous counter clear
//               hit_count, miss_count, wb_count - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module victim_cache_control
  import lc3b_types::*;
#(
  parameter int CNT_W = VICTIM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_read,
  input  logic             v_write,
  output logic             v_resp,
  input  logic             read_hit,
  input  logic             valid,
  output logic             victim_write,
  output logic             load_plru,
  output logic             load_plru_sel,
  output logic             address_sel,
  output logic             p_read,
  output logic             p_write,
  input  logic             p_resp,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  victim_ctrl_state_t r_state;
  victim_ctrl_state_t w_next_state;

  logic w_hit_inc;
  logic w_miss_inc;
  logic w_wb_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next_state  = r_state;
    v_resp        = 1'b0;
    victim_write  = 1'b0;
    load_plru     = 1'b0;
    load_plru_sel = 1'b0;
    address_sel   = 1'b0;
    p_read        = 1'b0;
    p_write       = 1'b0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    w_wb_inc      = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Evictions take precedence over reads
        if (v_write) begin
          w_next_state = valid ? WB : VWRITE;
        end else if (v_read) begin
          w_next_state = read_hit ? HIT : FETCH;
        end
      end

      HIT: begin
        v_resp        = 1'b1;
        load_plru     = 1'b1;
        load_plru_sel = 1'b1;
        w_hit_inc     = 1'b1;
        w_next_state  = DONE;
      end

      FETCH: begin
        p_read = 1'b1;
        // Memory data passes straight through to L2, so completion is
        // reported in the same cycle memory responds.
        if (p_resp) begin
          v_resp       = 1'b1;
          w_miss_inc   = 1'b1;
          w_next_state = DONE;
        end
      end

      WB: begin
        p_write     = 1'b1;
        address_sel = 1'b1;
        if (p_resp) begin
          w_wb_inc     = 1'b1;
          w_next_state = VWRITE;
        end
      end

      VWRITE: begin
        victim_write  = 1'b1;
        load_plru     = 1'b1;
        load_plru_sel = 1'b0;
        v_resp        = 1'b1;
        w_next_state  = DONE;
      end

      DONE: begin
        // Idle turnaround so a request still held by L2 is not re-accepted
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counts),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counts),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counts),
    .inc   (w_wb_inc),
    .count (wb_count)
  );

endmodule
`default_nettype wire
